// File: rtl/vlsu_pkg.sv
// Shared encodings for the vector load/store sequencer: SEW codes, FSM states,
// the per-SEW byte-enable and data masks, and the port count.
package vlsu_pkg;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      SEW8    = 2'b00,
      SEW16   = 2'b01,
      SEW32   = 2'b10,
      SEW_RSV = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Memory byte-enable encoding: bit0 = byte0, bit1 = byte1, bit2 = bytes 2-3.
   function automatic logic [2:0] sew_en_mask(input logic [1:0] sew);
      case (sew)
         SEW8:    sew_en_mask = 3'b001;
         SEW16:   sew_en_mask = 3'b011;
         default: sew_en_mask = 3'b111;
      endcase
   endfunction

   function automatic logic [31:0] sew_data_mask(input logic [1:0] sew);
      case (sew)
         SEW8:    sew_data_mask = 32'h0000_00FF;
         SEW16:   sew_data_mask = 32'h0000_FFFF;
         default: sew_data_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/vlsu_lane.sv
// One memory port of the sequencer: turns an element slot into enables,
// address and write data, and trims the returned load data to SEW.
module vlsu_lane
   import vlsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  active,
   input  logic                  op_store,
   input  logic [1:0]            sew,
   input  logic [ADDR_WIDTH-1:0] lane_addr,
   input  logic [31:0]           st_elem,
   input  logic [31:0]           rdata,
   output logic [2:0]            we,
   output logic [2:0]            re,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [31:0]           wdata,
   output logic [31:0]           ld_elem
);

   logic [2:0]  en;
   logic [31:0] dmask;

   always_comb begin
      en    = sew_en_mask(sew);
      dmask = sew_data_mask(sew);
      we    = '0;
      re    = '0;
      addr  = '0;
      wdata = '0;
      // Idle ports present an all-zero bus so the memory sees no stray traffic.
      if (active) begin
         addr = lane_addr;
         if (op_store) begin
            we    = en;
            wdata = st_elem & dmask;
         end else begin
            re = en;
         end
      end
      ld_elem = rdata & dmask;
   end

endmodule

// File: rtl/vlsu_seq.sv
// Vector load/store sequencer: walks one vector memory instruction in groups
// of four elements, one per memory port, and collects load results.
module vlsu_seq
   import vlsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int VLMAX      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    op_store,
   input  logic [1:0]              sew,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [ADDR_WIDTH-1:0]   stride,
   input  logic [$clog2(VLMAX):0]  vl,
   input  logic [VLMAX*32-1:0]     vs_data,
   output logic [VLMAX*32-1:0]     vd_data,
   output logic                    busy,
   output logic                    done,
   output logic [2:0]              mem_we0,
   output logic [2:0]              mem_we1,
   output logic [2:0]              mem_we2,
   output logic [2:0]              mem_we3,
   output logic [2:0]              mem_re0,
   output logic [2:0]              mem_re1,
   output logic [2:0]              mem_re2,
   output logic [2:0]              mem_re3,
   output logic [ADDR_WIDTH-1:0]   mem_addr0,
   output logic [ADDR_WIDTH-1:0]   mem_addr1,
   output logic [ADDR_WIDTH-1:0]   mem_addr2,
   output logic [ADDR_WIDTH-1:0]   mem_addr3,
   output logic [31:0]             mem_wdata0,
   output logic [31:0]             mem_wdata1,
   output logic [31:0]             mem_wdata2,
   output logic [31:0]             mem_wdata3,
   input  logic [31:0]             mem_rdata0,
   input  logic [31:0]             mem_rdata1,
   input  logic [31:0]             mem_rdata2,
   input  logic [31:0]             mem_rdata3
);

   localparam int IW  = $clog2(VLMAX);
   localparam int VLW = IW + 1;
   localparam int GW  = VLW - 2;

   state_e                  state, state_nx;
   logic                    run;
   logic                    op_q;
   logic [1:0]              sew_q;
   logic [ADDR_WIDTH-1:0]   stride_q;
   logic [ADDR_WIDTH-1:0]   addr0_q;
   logic [VLW-1:0]          vl_q;
   logic [GW-1:0]           grp_q;
   logic [VLW-1:0]          vl_clamp;
   logic [VLW:0]            next_e;
   logic                    last_grp;
   logic [VLMAX-1:0][31:0]  vd_q;
   logic [VLMAX-1:0][31:0]  vs_arr;

   logic [LANES-1:0]                 lane_act;
   logic [LANES-1:0][VLW-1:0]        lane_e;
   logic [LANES-1:0][IW-1:0]         lane_idx;
   logic [LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
   logic [LANES-1:0][31:0]           st_elem;
   logic [LANES-1:0][31:0]           rdata_a;
   logic [LANES-1:0][2:0]            we_a, re_a;
   logic [LANES-1:0][ADDR_WIDTH-1:0] addr_a;
   logic [LANES-1:0][31:0]           wdata_a, ld_elem;

   assign vs_arr   = vs_data;
   assign vd_data  = vd_q;
   assign rdata_a  = {mem_rdata3, mem_rdata2, mem_rdata1, mem_rdata0};
   assign vl_clamp = (vl > VLW'(VLMAX)) ? VLW'(VLMAX) : vl;
   // The group is the last one once the first element of the next group is past vl.
   assign next_e   = {1'b0, grp_q, 2'b00} + (VLW+1)'(LANES);
   assign last_grp = next_e >= {1'b0, vl_q};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (vl_clamp == '0) ? DONE : RUN;
         RUN:     if (last_grp) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      run  = (state == RUN);
      busy = (state == RUN) || (state == DONE);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= 1'b0;
         sew_q    <= '0;
         stride_q <= '0;
         addr0_q  <= '0;
         vl_q     <= '0;
         grp_q    <= '0;
         vd_q     <= '0;
      end else if (state == IDLE && start) begin
         op_q     <= op_store;
         sew_q    <= sew;
         stride_q <= stride;
         addr0_q  <= base_addr;
         vl_q     <= vl_clamp;
         grp_q    <= '0;
      end else if (run) begin
         grp_q   <= grp_q + 1'b1;
         addr0_q <= addr0_q + (stride_q << 2);
         for (int k = 0; k < LANES; k++)
            if (lane_act[k] && !op_q) vd_q[lane_idx[k]] <= ld_elem[k];
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_e[k]    = {grp_q, 2'(k)};
      assign lane_idx[k]  = lane_e[k][IW-1:0];
      assign lane_act[k]  = run && (lane_e[k] < vl_q);
      assign lane_addr[k] = addr0_q + ADDR_WIDTH'(k) * stride_q;
      assign st_elem[k]   = vs_arr[lane_idx[k]];

      vlsu_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
         .active    (lane_act[k]),
         .op_store  (op_q),
         .sew       (sew_q),
         .lane_addr (lane_addr[k]),
         .st_elem   (st_elem[k]),
         .rdata     (rdata_a[k]),
         .we        (we_a[k]),
         .re        (re_a[k]),
         .addr      (addr_a[k]),
         .wdata     (wdata_a[k]),
         .ld_elem   (ld_elem[k])
      );
   end

   assign mem_we0    = we_a[0];
   assign mem_we1    = we_a[1];
   assign mem_we2    = we_a[2];
   assign mem_we3    = we_a[3];
   assign mem_re0    = re_a[0];
   assign mem_re1    = re_a[1];
   assign mem_re2    = re_a[2];
   assign mem_re3    = re_a[3];
   assign mem_addr0  = addr_a[0];
   assign mem_addr1  = addr_a[1];
   assign mem_addr2  = addr_a[2];
   assign mem_addr3  = addr_a[3];
   assign mem_wdata0 = wdata_a[0];
   assign mem_wdata1 = wdata_a[1];
   assign mem_wdata2 = wdata_a[2];
   assign mem_wdata3 = wdata_a[3];

endmodule

// File: tb/tb_vlsu_seq.sv
// Bench for vlsu_seq: a byte-array data memory on the ports and an
// element-by-element reference of each instruction's effect.
module tb_vlsu_seq;

   localparam int AW    = 10;
   localparam int VLMAX = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst, start, op_store;
   logic [1:0]           sew;
   logic [AW-1:0]        base_addr, stride;
   logic [5:0]           vl;
   logic [VLMAX*32-1:0]  vs_data;
   logic [VLMAX*32-1:0]  vd_data;
   logic                 busy, done;
   logic [2:0]           mem_we0, mem_we1, mem_we2, mem_we3;
   logic [2:0]           mem_re0, mem_re1, mem_re2, mem_re3;
   logic [AW-1:0]        mem_addr0, mem_addr1, mem_addr2, mem_addr3;
   logic [31:0]          mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3;
   logic [31:0]          mem_rdata0, mem_rdata1, mem_rdata2, mem_rdata3;

   vlsu_seq #(.ADDR_WIDTH(AW), .VLMAX(VLMAX)) dut (
      .clk(clk), .rst(rst), .start(start), .op_store(op_store), .sew(sew),
      .base_addr(base_addr), .stride(stride), .vl(vl), .vs_data(vs_data),
      .vd_data(vd_data), .busy(busy), .done(done),
      .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_we3(mem_we3),
      .mem_re0(mem_re0), .mem_re1(mem_re1), .mem_re2(mem_re2), .mem_re3(mem_re3),
      .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_addr3(mem_addr3),
      .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2), .mem_wdata3(mem_wdata3),
      .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2), .mem_rdata3(mem_rdata3)
   );

   logic [2:0]    we_a [4];
   logic [2:0]    re_a [4];
   logic [AW-1:0] addr_a [4];
   logic [31:0]   wd_a [4];
   logic [31:0]   rd_a [4];
   assign we_a[0] = mem_we0;  assign we_a[1] = mem_we1;  assign we_a[2] = mem_we2;  assign we_a[3] = mem_we3;
   assign re_a[0] = mem_re0;  assign re_a[1] = mem_re1;  assign re_a[2] = mem_re2;  assign re_a[3] = mem_re3;
   assign addr_a[0] = mem_addr0;  assign addr_a[1] = mem_addr1;  assign addr_a[2] = mem_addr2;  assign addr_a[3] = mem_addr3;
   assign wd_a[0] = mem_wdata0;  assign wd_a[1] = mem_wdata1;  assign wd_a[2] = mem_wdata2;  assign wd_a[3] = mem_wdata3;
   assign mem_rdata0 = rd_a[0];  assign mem_rdata1 = rd_a[1];  assign mem_rdata2 = rd_a[2];  assign mem_rdata3 = rd_a[3];

   logic [7:0]  mem     [1024];
   logic [7:0]  ref_mem [1024];
   logic [31:0] ref_vd  [VLMAX];

   int checks = 0;
   int errors = 0;

   logic [2:0]    tr_we   [64][4];
   logic [2:0]    tr_re   [64][4];
   logic [AW-1:0] tr_addr [64][4];
   int            cyc_n;

   // Combinational read port of the data memory; disabled bytes read as 0.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_a[k] = '0;
         if (re_a[k][0]) rd_a[k][7:0]   = mem[addr_a[k]];
         if (re_a[k][1]) rd_a[k][15:8]  = mem[AW'(addr_a[k] + 1)];
         if (re_a[k][2]) rd_a[k][31:16] = {mem[AW'(addr_a[k] + 3)], mem[AW'(addr_a[k] + 2)]};
      end
   end

   // One clock: commit the store bus seen before the edge in port order, then step past the edge.
   task automatic tick();
      logic [2:0]    w [4];
      logic [AW-1:0] a [4];
      logic [31:0]   d [4];
      for (int k = 0; k < 4; k++) begin
         w[k] = we_a[k]; a[k] = addr_a[k]; d[k] = wd_a[k];
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (w[k][0]) mem[a[k]] = d[k][7:0];
         if (w[k][1]) mem[AW'(a[k] + 1)] = d[k][15:8];
         if (w[k][2]) begin
            mem[AW'(a[k] + 2)] = d[k][23:16];
            mem[AW'(a[k] + 3)] = d[k][31:24];
         end
      end
      #1;
   endtask

   function automatic int nbytes(input logic [1:0] sw);
      return (sw == 2'b00) ? 1 : (sw == 2'b01) ? 2 : 4;
   endfunction

   // Reference effect of one instruction, element by element in element order.
   task automatic ref_apply(input bit st, input logic [1:0] sw, input int b, input int s, input int vlv);
      int n;
      n = (vlv > VLMAX) ? VLMAX : vlv;
      for (int e = 0; e < n; e++) begin
         int a;
         logic [31:0] v;
         a = (b + e * s) % 1024;
         if (st) begin
            v = vs_data[32*e +: 32];
            for (int i = 0; i < nbytes(sw); i++) ref_mem[(a + i) % 1024] = v[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nbytes(sw); i++) v[8*i +: 8] = ref_mem[(a + i) % 1024];
            ref_vd[e] = v;
         end
      end
   endtask

   task automatic check_all(input string nm);
      int bad_at;
      for (int e = 0; e < VLMAX; e++) begin
         checks++;
         if (vd_data[32*e +: 32] !== ref_vd[e]) begin
            errors++;
            $display("FAIL %s vd[%0d] got %08h want %08h", nm, e, vd_data[32*e +: 32], ref_vd[e]);
         end
      end
      bad_at = -1;
      for (int i = 0; i < 1024; i++) if (bad_at < 0 && mem[i] !== ref_mem[i]) bad_at = i;
      checks++;
      if (bad_at >= 0) begin
         errors++;
         $display("FAIL %s mem[%03h] got %02h want %02h", nm, bad_at, mem[bad_at], ref_mem[bad_at]);
      end
   endtask

   task automatic run_instr(input string nm, input bit st, input logic [1:0] sw,
                            input logic [AW-1:0] b, input logic [AW-1:0] s, input int vlv);
      int n, bad;
      logic [2:0] m, exp_en;
      n = (vlv > VLMAX) ? VLMAX : vlv;
      m = (sw == 2'b00) ? 3'b001 : (sw == 2'b01) ? 3'b011 : 3'b111;
      op_store = st; sew = sw; base_addr = b; stride = s; vl = 6'(vlv); start = 1'b1;
      tick();
      start = 1'b0;
      cyc_n = 0;
      while (done !== 1'b1 && cyc_n < 60) begin
         for (int k = 0; k < 4; k++) begin
            tr_we[cyc_n][k] = we_a[k]; tr_re[cyc_n][k] = re_a[k]; tr_addr[cyc_n][k] = addr_a[k];
         end
         tick();
         cyc_n++;
      end
      checks++;
      if (done !== 1'b1 || cyc_n != (n + 3) / 4) begin
         errors++;
         $display("FAIL %s run_len got %0d cycles (done=%b) want %0d", nm, cyc_n, done, (n + 3) / 4);
      end
      // Enables and addresses per cycle, plus a quiet bus during DONE.
      bad = 0;
      for (int c = 0; c < cyc_n; c++)
         for (int k = 0; k < 4; k++) begin
            exp_en = (4 * c + k < n) ? m : 3'b000;
            if (tr_we[c][k] !== (st ? exp_en : 3'b000)) bad++;
            if (tr_re[c][k] !== (st ? 3'b000 : exp_en)) bad++;
            if (exp_en != 0 && tr_addr[c][k] !== AW'((int'(b) + (4 * c + k) * int'(s)) % 1024)) bad++;
         end
      for (int k = 0; k < 4; k++) if (we_a[k] !== 3'b000 || re_a[k] !== 3'b000) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s port_trace got %0d bad fields want 0", nm, bad);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done got busy=%b done=%b want 0 0", nm, busy, done);
      end
      ref_apply(st, sw, int'(b), int'(s), vlv);
      check_all(nm);
   endtask

   task automatic clear_ref_vd();
      for (int e = 0; e < VLMAX; e++) ref_vd[e] = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op_store = 1'b0; sew = '0; base_addr = '0; stride = '0; vl = '0;
      vs_data = '0;
      for (int i = 0; i < 1024; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
      clear_ref_vd();
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || vd_data !== '0 ||
          {mem_we0, mem_we1, mem_we2, mem_we3, mem_re0, mem_re1, mem_re2, mem_re3} !== '0 ||
          {mem_addr0, mem_addr1, mem_addr2, mem_addr3} !== '0 ||
          {mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b we0=%b re0=%b addr0=%h", busy, done, mem_we0, mem_re0, mem_addr0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_unit_load();
      for (int i = 0; i < 32; i++) begin mem[i] = 8'(i); ref_mem[i] = 8'(i); end
      run_instr("unit_load", 1'b0, 2'b10, 10'h000, 10'd4, 8);
      checks++;
      if (vd_data[31:0] !== 32'h0302_0100 || vd_data[32*7 +: 32] !== 32'h1F1E_1D1C) begin
         errors++;
         $display("FAIL unit_load_words got %08h %08h want 03020100 1f1e1d1c", vd_data[31:0], vd_data[32*7 +: 32]);
      end
   endtask

   task automatic test_byte_store();
      logic [7:0] b45;
      for (int i = 'h40; i < 'h48; i++) begin mem[i] = 8'h5A; ref_mem[i] = 8'h5A; end
      b45 = 8'h5A;
      for (int e = 0; e < VLMAX; e++) vs_data[32*e +: 32] = 32'hFFFF_FF00 | (32'hA0 + e);
      run_instr("byte_store", 1'b1, 2'b00, 10'h040, 10'd1, 5);
      checks++;
      if (tr_we[1][0] !== 3'b001 || tr_we[1][1] !== 3'b000 || tr_we[1][2] !== 3'b000 || tr_we[1][3] !== 3'b000) begin
         errors++;
         $display("FAIL byte_store_cycle2 got %b %b %b %b want 001 000 000 000", tr_we[1][0], tr_we[1][1], tr_we[1][2], tr_we[1][3]);
      end
      checks++;
      if ({mem['h44], mem['h43], mem['h42], mem['h41], mem['h40]} !== 40'hA4A3A2A1A0 || mem['h45] !== b45) begin
         errors++;
         $display("FAIL byte_store_mem got %02h..%02h next %02h want a0..a4 next %02h", mem['h40], mem['h44], mem['h45], b45);
      end
   endtask

   task automatic test_stride_half();
      for (int i = 0; i < 1024; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
      run_instr("stride_half", 1'b0, 2'b01, 10'h3FE, 10'd6, 3);
      checks++;
      if (tr_addr[0][0] !== 10'h3FE || tr_addr[0][1] !== 10'h004 || tr_addr[0][2] !== 10'h00A || tr_re[0][1] !== 3'b011) begin
         errors++;
         $display("FAIL stride_half_addr got %h %h %h re1=%b want 3fe 004 00a 011", tr_addr[0][0], tr_addr[0][1], tr_addr[0][2], tr_re[0][1]);
      end
   endtask

   task automatic test_vl_edges();
      run_instr("vl_zero", 1'b0, 2'b10, 10'h100, 10'd4, 0);
      run_instr("vl_clamp", 1'b0, 2'b10, 10'h010, 10'd4, 40);
      checks++;
      if (cyc_n != 8) begin
         errors++;
         $display("FAIL vl_clamp_cycles got %0d want 8", cyc_n);
      end
   endtask

   task automatic test_overlap();
      for (int e = 0; e < VLMAX; e++) vs_data[32*e +: 32] = 32'(e + 1);
      run_instr("overlap", 1'b1, 2'b10, 10'h100, 10'd0, 4);
      checks++;
      if ({mem['h103], mem['h102], mem['h101], mem['h100]} !== 32'h0000_0004) begin
         errors++;
         $display("FAIL overlap_word got %02h%02h%02h%02h want 00000004", mem['h103], mem['h102], mem['h101], mem['h100]);
      end
   endtask

   task automatic test_reset_mid();
      op_store = 1'b0; sew = 2'b10; base_addr = 10'h000; stride = 10'd4; vl = 6'd32; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({mem_we0, mem_we1, mem_we2, mem_we3, mem_re0, mem_re1, mem_re2, mem_re3} !== '0 || busy !== 1'b0 || vd_data !== '0) begin
         errors++;
         $display("FAIL reset_mid got re0=%b busy=%b vd0=%08h want 000 0 0", mem_re0, busy, vd_data[31:0]);
      end
      rst = 1'b0;
      clear_ref_vd();
      tick();
      run_instr("after_reset", 1'b0, 2'b01, 10'h020, 10'd2, 13);
   endtask

   task automatic test_random();
      for (int i = 0; i < 1024; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
      for (int t = 0; t < 10; t++) begin
         for (int e = 0; e < VLMAX; e++) vs_data[32*e +: 32] = $urandom;
         run_instr($sformatf("rand%0d", t), 1'($urandom), 2'($urandom), 10'($urandom), 10'($urandom_range(0, 12)),
                   int'($urandom_range(0, 40)));
      end
   endtask

   initial begin
      test_reset();
      test_unit_load();
      test_byte_store();
      test_stride_half();
      test_vl_edges();
      test_overlap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
